// File: rtl/dio24_btn_events_if.sv
// Button-event bus: debounced button levels in, event pulses, sticky flags,
// IRQ and per-LED feedback controls out.
interface dio24_btn_events_if #(
  parameter int NUM_BUTTONS = 2
);
  logic [NUM_BUTTONS-1:0]   btn_status;
  logic [NUM_BUTTONS-1:0]   evt_short;
  logic [NUM_BUTTONS-1:0]   evt_long;
  logic [NUM_BUTTONS-1:0]   evt_double;
  logic [3*NUM_BUTTONS-1:0] evt_sts;
  logic [3*NUM_BUTTONS-1:0] evt_clr;
  logic                     evt_irq;
  logic [NUM_BUTTONS-1:0]   leds_on;
  logic [NUM_BUTTONS-1:0]   leds_bright;
  logic [NUM_BUTTONS-1:0]   leds_blink;
  logic [NUM_BUTTONS-1:0]   leds_high;

  modport master (
    output btn_status, evt_clr,
    input  evt_short, evt_long, evt_double, evt_sts, evt_irq,
    input  leds_on, leds_bright, leds_blink, leds_high
  );

  modport slave (
    input  btn_status, evt_clr,
    output evt_short, evt_long, evt_double, evt_sts, evt_irq,
    output leds_on, leds_bright, leds_blink, leds_high
  );
endinterface

// File: rtl/dio24_btn_events.sv
// Button press classifier (short/long/double) with sticky flags, IRQ and
// LED feedback. One lane instance per button, shared tick prescaler.
module dio24_btn_lane #(
  parameter int TICK_BITS    = 10,
  parameter int LONG_TICKS   = 500,
  parameter int DOUBLE_TICKS = 200,
  parameter int FB_TICKS     = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic       btn_i,
  output logic [2:0] evt_o,   // {double, long, short}
  output logic [3:0] led_o    // {high, blink, bright, on}
);
  typedef enum logic [1:0] {IDLE, PRESS, GAP, HELD} state_e;

  localparam logic [TICK_BITS-1:0] LONG_LAST = TICK_BITS'(LONG_TICKS - 1);
  localparam logic [TICK_BITS-1:0] DBL_LAST  = TICK_BITS'(DOUBLE_TICKS - 1);
  localparam logic [TICK_BITS-1:0] FB_LAST   = TICK_BITS'(FB_TICKS - 1);

  state_e               state_q, state_d;
  logic [TICK_BITS-1:0] tcnt_q, tcnt_d, fb_cnt_q, fb_cnt_d;
  logic [2:0]           emit_q, emit_d, evt_q, fb_type_q, fb_type_d;
  logic                 fb_act_q, fb_act_d;
  logic [3:0]           led_q, led_d;

  always_comb begin
    state_d = state_q;
    emit_d  = 3'b000;
    tcnt_d  = tcnt_q;
    if (tick_i && tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
    case (state_q)
      IDLE:  if (btn_i) state_d = PRESS;
      PRESS: if (!btn_i) state_d = GAP;
             else if (tick_i && tcnt_q == LONG_LAST) begin
               emit_d  = 3'b010;
               state_d = HELD;
             end
      GAP:   if (btn_i) begin
               emit_d  = 3'b100;
               state_d = HELD;
             end else if (tick_i && tcnt_q == DBL_LAST) begin
               emit_d  = 3'b001;
               state_d = IDLE;
             end
      HELD:  if (!btn_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) tcnt_d = '0;
  end

  // Feedback keys off emit_q so the LEDs change on the same edge as evt_o.
  always_comb begin
    fb_act_d  = fb_act_q;
    fb_type_d = fb_type_q;
    fb_cnt_d  = fb_cnt_q;
    if (|emit_q) begin
      fb_act_d  = 1'b1;
      fb_type_d = emit_q;
      fb_cnt_d  = '0;
    end else if (fb_act_q && tick_i) begin
      if (fb_cnt_q == FB_LAST) fb_act_d = 1'b0;
      else                     fb_cnt_d = fb_cnt_q + 1'b1;
    end
    if (fb_act_d) led_d = {fb_type_d[1], fb_type_d[2] | fb_type_d[1], 2'b11};
    else          led_d = {3'b000, btn_i};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      emit_q    <= '0;
      evt_q     <= '0;
      fb_act_q  <= 1'b0;
      fb_type_q <= '0;
      fb_cnt_q  <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      emit_q    <= emit_d;
      evt_q     <= emit_q;
      fb_act_q  <= fb_act_d;
      fb_type_q <= fb_type_d;
      fb_cnt_q  <= fb_cnt_d;
      led_q     <= led_d;
    end
  end

  assign evt_o = evt_q;
  assign led_o = led_q;
endmodule

module dio24_btn_events #(
  parameter int NUM_BUTTONS  = 2,
  parameter int PRESC_BITS   = 16,
  parameter int TICK_BITS    = 10,
  parameter int LONG_TICKS   = 500,
  parameter int DOUBLE_TICKS = 200,
  parameter int FB_TICKS     = 300
) (
  input logic               clk,
  input logic               reset_n,
  dio24_btn_events_if.slave bus
);
  localparam int NB = NUM_BUTTONS;

  logic [PRESC_BITS-1:0] presc_q;
  logic                  tick;
  logic [NB-1:0][2:0]    evt;
  logic [NB-1:0][3:0]    led;
  logic [3*NB-1:0]       pulse, sts_q, sts_d;
  logic                  irq_q;
  logic [NB-1:0]         on, bright, blink, high;

  assign tick = &presc_q;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    dio24_btn_lane #(
      .TICK_BITS(TICK_BITS), .LONG_TICKS(LONG_TICKS),
      .DOUBLE_TICKS(DOUBLE_TICKS), .FB_TICKS(FB_TICKS)
    ) u_lane (
      .clk, .reset_n, .tick_i(tick), .btn_i(bus.btn_status[i]),
      .evt_o(evt[i]), .led_o(led[i])
    );
  end

  always_comb begin
    pulse  = '0;
    on     = '0;
    bright = '0;
    blink  = '0;
    high   = '0;
    for (int i = 0; i < NB; i++) begin
      pulse[i]        = evt[i][0];
      pulse[NB+i]     = evt[i][1];
      pulse[2*NB+i]   = evt[i][2];
      on[i]           = led[i][0];
      bright[i]       = led[i][1];
      blink[i]        = led[i][2];
      high[i]         = led[i][3];
    end
    // set beats clear when both land in the same cycle
    sts_d = (sts_q & ~bus.evt_clr) | pulse;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      sts_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_q + 1'b1;
      sts_q   <= sts_d;
      irq_q   <= |sts_q;
    end
  end

  assign bus.evt_short   = pulse[NB-1:0];
  assign bus.evt_long    = pulse[2*NB-1:NB];
  assign bus.evt_double  = pulse[3*NB-1:2*NB];
  assign bus.evt_sts     = sts_q;
  assign bus.evt_irq     = irq_q;
  assign bus.leds_on     = on;
  assign bus.leds_bright = bright;
  assign bus.leds_blink  = blink;
  assign bus.leds_high   = high;
endmodule

// File: doc/dio24_btn_events.md
Name: dio24_btn_events

Overview:
- Consumer side of the debounced button / LED-control interface. Takes debounced button levels (btn_status) and classifies each press as short, long or double.
- Emits one-cycle event pulses plus sticky, clearable event flags with an IRQ line.
- Drives the per-LED control bits (on/bright/blink/high) to give visual feedback for each recognised event.
- Sits between the button/LED I/O block and the register/interrupt logic.

Parameters:
NUM_BUTTONS, 2, number of buttons; LED feedback lanes equal buttons.
PRESC_BITS, 16, prescaler width; one tick every 2^PRESC_BITS clk cycles.
TICK_BITS, 10, width of per-button tick counters.
LONG_TICKS, 500, ticks a press must be held to count as long (1 <= LONG_TICKS < 2^TICK_BITS).
DOUBLE_TICKS, 200, maximum ticks between release and second press for a double.
FB_TICKS, 300, ticks the LED feedback stays active after an event.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
btn_status  in  NUM_BUTTONS  debounced button level, 1 = pressed; already synchronous to clk
evt_short  out  NUM_BUTTONS  one-cycle pulse, short press recognised
evt_long  out  NUM_BUTTONS  one-cycle pulse, long press recognised
evt_double  out  NUM_BUTTONS  one-cycle pulse, double press recognised
evt_sts  out  3*NUM_BUTTONS  sticky flags: [NB-1:0] short, [2NB-1:NB] long, [3NB-1:2NB] double
evt_clr  in  3*NUM_BUTTONS  per-flag clear, same layout, level-sensitive
evt_irq  out  1  OR of all evt_sts bits, registered
leds_on  out  NUM_BUTTONS  LED on/off to LED driver
leds_bright  out  NUM_BUTTONS  1 = bright, 0 = dim
leds_blink  out  NUM_BUTTONS  1 = blink
leds_high  out  NUM_BUTTONS  1 = fast blink

Behaviour:
- Reset: reset_n synchronous, active-low; clock clk.
  - Prescaler, all counters and all outputs reset to 0.
  - All FSMs go to IDLE; feedback goes inactive.
  - Reset mid-press discards the press. A button still held after reset enters PRESS on the first cycle out of reset.
- Prescaler: a free-running PRESC_BITS counter shared by all buttons. tick = 1 for the single cycle when it is all ones.
- Per-button FSM, with state counter tcnt:
  - tcnt clears on every state entry.
  - tcnt increments on tick and saturates at all ones.
  - Timeout condition = tick && tcnt == N-1, i.e. the N-th tick after entry.
- IDLE: btn=1 -> PRESS.
- PRESS:
  - btn=0 -> GAP.
  - Else on LONG timeout: emit long, go to HELD.
  - Release has priority over timeout in the same cycle (goes to GAP, no long).
- GAP:
  - btn=1 -> emit double, go to HELD.
  - Else on DOUBLE timeout: emit short, go to IDLE.
  - Press has priority over timeout in the same cycle (double wins).
- HELD: btn=0 -> IDLE. No further events while held.
- Event latency: the condition is sampled at edge k; the evt_* pulse is high for exactly one cycle after edge k+1. At most one event type per button per cycle.
- Sticky flags:
  - A flag sets on its pulse and clears when its evt_clr bit is 1.
  - Set and clear in the same cycle: set wins.
  - evt_irq updates one cycle after evt_sts.
- LED feedback, per button:
  - Any event loads fb_cnt = 0 and fb_type, and activates feedback. A new event during active feedback restarts it with the new type.
  - Feedback deactivates on FB timeout.
  - Active short: on=1, bright=1, blink=0, high=0.
  - Active long: on=1, bright=1, blink=1, high=1.
  - Active double: on=1, bright=1, blink=1, high=0.
  - Inactive: on=btn_status (registered), bright=0, blink=0, high=0.
  - LED outputs are registered and change on the same edge as the evt_* pulse.
- Buttons are fully independent. Simultaneous events on different buttons are all reported in the same cycle.

Test Plan:
Test parameters: NB=2, PRESC_BITS=2, TICK_BITS=4, LONG_TICKS=8, DOUBLE_TICKS=4, FB_TICKS=6.
- Reset/idle: reset_n=0 for 3 clk, btn=0 -> all outputs 0; evt_sts=6'b0; evt_irq=0 throughout.
- Short press: btn[0] high 10 clk then low -> evt_short[0] one-cycle pulse 13..17 clk after release. evt_sts[0]=1, then evt_irq=1. leds 1/1/0/0 for about 24 clk.
- Long press: btn[1] high 40 clk -> evt_long[1] pulse 29..33 clk after press. evt_sts[3]=1; leds[1] on/bright/blink/high=1. No short on release.
- Double: btn[0] high 6, low 6, high 6 -> evt_double[0] 2 clk after the second rising edge. evt_sts[4]=1; no short, no long.
- Clear priority: assert evt_clr[0] in the same cycle as a new evt_short[0] -> evt_sts[0] stays 1. Assert evt_clr[0] alone -> cleared next cycle; evt_irq drops one cycle later.
- Reset mid-press: btn[0] held 20 clk, pulse reset_n, keep holding 40 clk -> long is reported only 29..33 clk after reset release. No event from the pre-reset hold.
